// File: rtl/keypad_encoder_rpt.sv
// Debounced priority keypad encoder with auto-repeat while a key is held,
// a free-running tick divider, and a pgt output muxing valid/tick.
module keypad_encoder_rpt #(
    parameter int unsigned NKEYS        = 10,
    parameter int unsigned CW           = 4,
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned REPEAT_TICKS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] keys,
    input  logic             en,
    output logic [CW-1:0]    code,
    output logic             valid,
    output logic             tick,
    output logic             pgt,
    output logic             load
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_TICKS - 1);
    localparam bit            DEB_ONE   = (DEB_CYCLES == 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, nxt;
    logic [CW-1:0] samp, cand;
    logic          any;
    logic [DW-1:0] deb_cnt, zero_cnt;
    logic [RW-1:0] rpt_cnt;
    logic [TW-1:0] tick_cnt;
    logic          restart, accept, deb_inc, zero_start, zero_inc, fire;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        samp = '0;
        any  = 1'b0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (keys[i]) begin
                samp = CW'(i);
                any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        restart    = 1'b0;
        accept     = 1'b0;
        deb_inc    = 1'b0;
        zero_start = 1'b0;
        zero_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (any) restart = 1'b1;
            end
            DEBOUNCE: begin
                if (!any)                   nxt = IDLE;
                else if (samp != cand)      restart = 1'b1;
                else if (deb_cnt == DEB_LAST) begin
                    accept = 1'b1;
                    nxt    = PRESSED;
                end else                    deb_inc = 1'b1;
            end
            PRESSED: begin
                if (!any) begin
                    zero_start = 1'b1;
                    nxt        = DEB_ONE ? IDLE : RELEASE;
                end else if (samp != cand) restart = 1'b1;
            end
            RELEASE: begin
                if (any)                        restart = 1'b1;
                else if (zero_cnt == DEB_LAST)  nxt = IDLE;
                else                            zero_inc = 1'b1;
            end
            default: nxt = IDLE;
        endcase
        // A fresh candidate already counts as one stable sample.
        if (restart) begin
            nxt    = DEB_ONE ? PRESSED : DEBOUNCE;
            accept = DEB_ONE;
        end
        fire = tick && (state == PRESSED) && (nxt == PRESSED) && !accept &&
               (rpt_cnt == RPT_LAST);
    end

    always_comb begin
        load = (state == IDLE);
        pgt  = en ? tick : valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            code     <= '0;
            deb_cnt  <= '0;
            zero_cnt <= '0;
            rpt_cnt  <= '0;
            valid    <= 1'b0;
        end else begin
            if (restart)      deb_cnt <= DW'(1);
            else if (deb_inc) deb_cnt <= deb_cnt + DW'(1);
            if (restart)      cand <= samp;

            if (zero_start)    zero_cnt <= DW'(1);
            else if (zero_inc) zero_cnt <= zero_cnt + DW'(1);

            if (accept) code <= restart ? samp : cand;

            if (nxt != PRESSED || accept || fire)   rpt_cnt <= '0;
            else if (tick && state == PRESSED)      rpt_cnt <= rpt_cnt + RW'(1);

            valid <= (accept | fire) & ~valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
            tick     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_encoder_rpt.sv
// Randomized bench for keypad_encoder_rpt: a run-length reference model feeds
// an expected-valid queue that a negedge monitor drains and compares.
module tb_keypad_encoder_rpt;

    localparam int NK   = 10;
    localparam int DEB  = 4;
    localparam int TDIV = 100;
    localparam int RPT  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] keys;
    logic       en;
    logic [3:0] code;
    logic       valid, tick, pgt, load;

    always #5 clk = ~clk;

    keypad_encoder_rpt #(
        .NKEYS(NK), .CW(4), .DEB_CYCLES(DEB), .TICK_DIV(TDIV), .REPEAT_TICKS(RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .en(en),
        .code(code), .valid(valid), .tick(tick), .pgt(pgt), .load(load)
    );

    typedef struct {int cyc; int code;} exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model: tracks the length of the current run of identical samples.
    int n, run_val, run_len, acc_code, rpt;
    bit held, nz_before_ok;
    bit exp_load, exp_tick;
    int exp_code;
    bit in_reset, started;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    function automatic int prio(input logic [9:0] k);
        return $clog2(int'(k) + 1) - 1;
    endfunction

    task automatic model_reset();
        n = 0; run_val = -1; run_len = 0; acc_code = 0; rpt = 0;
        held = 0; nz_before_ok = 0;
        exp_load = 1; exp_tick = 0; exp_code = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic [9:0] k);
        int s;
        bit tick_in, fire;
        s = prio(k);
        n++;
        tick_in = (n > 1) && ((n - 1) % TDIV == 0);
        fire = 0;
        if (s == run_val) run_len++;
        else begin
            if (s < 0) nz_before_ok = (run_len >= DEB);
            run_val = s; run_len = 1; held = 0;
        end
        if (s >= 0 && run_len == DEB) begin
            acc_code = s; held = 1; rpt = 0; fire = 1;
        end else if (held && tick_in) begin
            rpt++;
            if (rpt == RPT) begin rpt = 0; fire = 1; end
        end
        if (fire) sb.push_back('{n, acc_code});
        exp_tick = (n % TDIV == 0);
        exp_code = acc_code;
        exp_load = (s < 0) && (run_len >= DEB || !nz_before_ok);
    endtask

    always @(negedge clk) begin
        if (started && !in_reset) begin
            bit ev;
            ev = (sb.size() > 0) && (sb[0].cyc == n);
            chk("valid", int'(valid), int'(ev));
            if (ev) begin
                if (valid) chk("valid_code", int'(code), sb[0].code);
                void'(sb.pop_front());
            end
            chk("code", int'(code), exp_code);
            chk("load", int'(load), int'(exp_load));
            chk("tick", int'(tick), int'(exp_tick));
            chk("pgt", int'(pgt), en ? int'(exp_tick) : int'(ev));
        end
    end

    task automatic run(input logic [9:0] k, input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            keys = k;
            en   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 model_step(k);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_code"},  int'(code),  0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_tick"},  int'(tick),  0);
        chk({tag, "_load"},  int'(load),  1);
        chk({tag, "_pgt"},   int'(pgt),   0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        in_reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        int unsigned len;
        rst_n = 1'b0; keys = '0; en = 1'b0;
        in_reset = 1'b1; started = 1'b0;
        model_reset();
        #2 check_reset_vals("rst_init");
        #6 rst_n = 1'b1;
        in_reset = 1'b0;
        started  = 1'b1;

        run(10'h000, 5);
        run(10'h008, 10);  run(10'h000, 6);
        run(10'h008, 2);   run(10'h010, 8);  run(10'h000, 6);
        run(10'h201, 8);   run(10'h000, 6);
        run(10'h004, 8);   run(10'h000, 2);  run(10'h004, 8);  run(10'h000, 6);
        run(10'h020, 2000); run(10'h000, 6);
        run(10'h080, 50);  do_reset();
        run(10'h080, 10);  run(10'h000, 6);
        run(10'h040, 250); do_reset();
        run(10'h040, 300); run(10'h000, 6);

        pat = '0;
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0: pat = '0;
                1: pat = 10'd1 << $urandom_range(0, 9);
                2: pat = 10'($urandom);
                default: ;
            endcase
            len = ($urandom_range(0, 15) == 0) ? $urandom_range(500, 1200) : $urandom_range(1, 9);
            run(pat, len);
        end

        run(10'h000, 8);
        @(negedge clk);
        #1 chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
